uart_tx_framer: RTL and testbench

Byte-serialising UART transmitter that sits directly downstream of the baud clock generator. It consumes the generator's BCLK square wave and treats each BCLK rising edge as one bit period. Bytes are accepted over a valid/ready handshake into a one-entry holding register and emitted as start / data LSB-first / optional parity / stop frames on TX. Frames run back-to-back with no idle gap when the holding register is kept full.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_bclk_edge.sv | 22 ++
 rtl/uart_tx_framer.sv | 156 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants.
// Used by the baud generator, the framer and the future receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_bclk_edge.sv
// BCLK rising-edge detector, tick is combinational from BCLK and one flop.
// No backpressure; bclk_d resets high so a BCLK already high yields no tick.
module uart_bclk_edge (
   input  logic CLK,
   input  logic RESET,
   input  logic BCLK,
   output logic tick
);

   logic bclk_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         bclk_d <= 1'b1;
      end else begin
         bclk_d <= BCLK;
      end
   end

   assign tick = BCLK & ~bclk_d;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop framer.
// Start bit at first tick after accept; TX_READY low while the holding register is full.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 BCLK,
   input  logic [DATA_BITS-1:0] TX_DATA,
   input  logic                 TX_VALID,
   output logic                 TX_READY,
   output logic                 TX,
   output logic                 BUSY,
   output logic                 TX_DONE
);

   if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("uart_tx_framer: illegal DATA_BITS/PARITY_MODE/STOP_BITS");
   end

   localparam logic [2:0] CNT_LAST  = 3'(DATA_BITS - 1);
   localparam logic       STOP_LAST = (STOP_BITS == 2);

   uart_state_t          state_q, state_n;
   logic [DATA_BITS-1:0] shift_q, shift_n;
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_full;
   logic [2:0]           cnt_q, cnt_n;
   logic                 stop_q, stop_n;
   logic                 par_q, par_n;
   logic                 tx_q, tx_n;
   logic                 busy_q;
   logic                 done_q, done_n;
   logic                 load;
   logic                 tick;

   uart_bclk_edge u_edge (
      .CLK   (CLK),
      .RESET (RESET),
      .BCLK  (BCLK),
      .tick  (tick)
   );

   always_comb begin
      state_n = state_q;
      shift_n = shift_q;
      cnt_n   = cnt_q;
      stop_n  = stop_q;
      par_n   = par_q;
      tx_n    = tx_q;
      done_n  = 1'b0;
      load    = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE: begin
               if (hold_full) begin
                  load    = 1'b1;
                  state_n = START;
                  tx_n    = 1'b0;
               end
            end
            START: begin
               state_n = DATA;
               tx_n    = shift_q[0];
               cnt_n   = 3'd0;
            end
            DATA: begin
               if (cnt_q == CNT_LAST) begin
                  if (PARITY_MODE != PARITY_NONE) begin
                     state_n = PARITY;
                     tx_n    = par_q;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                     stop_n  = 1'b0;
                  end
               end else begin
                  shift_n = shift_q >> 1;
                  tx_n    = shift_q[1];
                  cnt_n   = cnt_q + 3'd1;
               end
            end
            PARITY: begin
               state_n = STOP;
               tx_n    = 1'b1;
               stop_n  = 1'b0;
            end
            STOP: begin
               if (stop_q == STOP_LAST) begin
                  done_n = 1'b1;
                  // Reload straight into START so back-to-back frames have no idle gap
                  if (hold_full) begin
                     load    = 1'b1;
                     state_n = START;
                     tx_n    = 1'b0;
                  end else begin
                     state_n = IDLE;
                     tx_n    = 1'b1;
                  end
               end else begin
                  stop_n = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               tx_n    = 1'b1;
            end
         endcase
      end
      if (load) begin
         shift_n = hold_data;
         par_n   = (PARITY_MODE == PARITY_ODD) ? ~^hold_data : ^hold_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         cnt_q     <= 3'd0;
         stop_q    <= 1'b0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hold_full <= 1'b0;
         hold_data <= '0;
      end else begin
         state_q <= state_n;
         shift_q <= shift_n;
         cnt_q   <= cnt_n;
         stop_q  <= stop_n;
         par_q   <= par_n;
         tx_q    <= tx_n;
         busy_q  <= (state_n != IDLE);
         done_q  <= done_n;
         if (load) begin
            hold_full <= 1'b0;
         end else if (TX_VALID && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= TX_DATA;
         end
      end
   end

   assign TX_READY = ~hold_full;
   assign TX       = tx_q;
   assign BUSY     = busy_q;
   assign TX_DONE  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Randomised bench for uart_tx_framer: four configurations (8N1, 8E1, 8O1, 7N2)
// checked bit-by-bit against a frame/timing model kept in the bench.
module tb_uart_tx_framer;

   localparam int NI = 4;
   localparam int DB [NI] = '{8, 8, 8, 7};
   localparam int PM [NI] = '{0, 2, 1, 0};
   localparam int SB [NI] = '{1, 1, 1, 2};

   logic       CLK;
   logic       RESET;
   logic       BCLK;
   logic [7:0] td   [NI];
   logic       tv   [NI];
   logic       trdy [NI];
   logic       tx   [NI];
   logic       busy [NI];
   logic       done [NI];

   int n_chk  = 0;
   int n_pass = 0;

   int bcnt = 15;
   int per  = 0;
   bit in_reset = 1'b0;

   logic [7:0]  exp_q [NI][$];
   int          st_q  [NI][$];
   int          lend      [NI];
   bit          mbusy     [NI];
   logic [15:0] mbits     [NI];
   int          mlen      [NI];
   int          midx      [NI];
   int          done_exp  [NI];
   int          dcnt      [NI];

   uart_tx_framer #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
      .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .TX_DATA(td[0]), .TX_VALID(tv[0]),
      .TX_READY(trdy[0]), .TX(tx[0]), .BUSY(busy[0]), .TX_DONE(done[0]));
   uart_tx_framer #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
      .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .TX_DATA(td[1]), .TX_VALID(tv[1]),
      .TX_READY(trdy[1]), .TX(tx[1]), .BUSY(busy[1]), .TX_DONE(done[1]));
   uart_tx_framer #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
      .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .TX_DATA(td[2]), .TX_VALID(tv[2]),
      .TX_READY(trdy[2]), .TX(tx[2]), .BUSY(busy[2]), .TX_DONE(done[2]));
   uart_tx_framer #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
      .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .TX_DATA(td[3][6:0]), .TX_VALID(tv[3]),
      .TX_READY(trdy[3]), .TX(tx[3]), .BUSY(busy[3]), .TX_DONE(done[3]));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int flen(input int k);
      return 1 + DB[k] + ((PM[k] != 0) ? 1 : 0) + SB[k];
   endfunction

   // Expected line levels for one frame, bit 0 = start bit; stop bits and beyond are 1.
   function automatic logic [15:0] frame_bits(input int k, input logic [7:0] d);
      logic [15:0] b;
      int ones;
      b    = '1;
      b[0] = 1'b0;
      ones = 0;
      for (int i = 0; i < DB[k]; i++) begin
         b[1 + i] = d[i];
         if (d[i]) ones++;
      end
      if (PM[k] == 1) b[1 + DB[k]] = ((ones % 2) == 0);
      if (PM[k] == 2) b[1 + DB[k]] = ((ones % 2) == 1);
      return b;
   endfunction

   function automatic bit all_idle();
      for (int k = 0; k < NI; k++) begin
         if (exp_q[k].size() != 0 || mbusy[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Mid-bit sample of every instance: detect starts, check each bit and BUSY.
   task automatic sample();
      logic [7:0] d;
      int s;
      if (in_reset) return;
      for (int k = 0; k < NI; k++) begin
         if (!mbusy[k]) begin
            if (tx[k] == 1'b0) begin
               chk($sformatf("start_busy[%0d]", k), 32'(busy[k]), 1);
               if (exp_q[k].size() == 0) begin
                  chk($sformatf("unexpected_start[%0d]", k), 0, 1);
               end else begin
                  d = exp_q[k].pop_front();
                  s = st_q[k].pop_front();
                  chk($sformatf("start_period[%0d]", k), per, s);
                  mbits[k] = frame_bits(k, d);
                  mlen[k]  = flen(k);
                  midx[k]  = 1;
                  mbusy[k] = 1'b1;
               end
            end else begin
               chk($sformatf("idle_busy[%0d]", k), 32'(busy[k]), 0);
            end
         end else begin
            chk($sformatf("frame_busy[%0d]", k), 32'(busy[k]), 1);
            chk($sformatf("frame_bit%0d[%0d]", midx[k], k), 32'(tx[k]), 32'(mbits[k][midx[k]]));
            midx[k]++;
            if (midx[k] == mlen[k]) begin
               mbusy[k] = 1'b0;
               done_exp[k]++;
            end
         end
      end
   endtask

   // BCLK: 16 CLK per bit, driven on the falling CLK edge; per = index of the current bit period.
   initial begin
      BCLK = 1'b0;
      forever begin
         @(negedge CLK);
         bcnt = (bcnt == 15) ? 0 : bcnt + 1;
         if (bcnt == 0) begin
            BCLK = 1'b1;
            per++;
         end
         if (bcnt == 8) begin
            BCLK = 1'b0;
            sample();
         end
      end
   end

   always @(negedge CLK) begin
      for (int k = 0; k < NI; k++) begin
         if (done[k] === 1'b1) dcnt[k]++;
      end
   end

   // Offer one byte; align = present it only on a CLK edge that is also a tick.
   task automatic send(input int k, input logic [7:0] d, input bit align);
      int n;
      int st;
      n = 0;
      @(negedge CLK); #1;
      if (!align) begin
         td[k] = d;
         tv[k] = 1'b1;
      end
      while (!(trdy[k] && (!align || bcnt == 0)) && n < 4000) begin
         @(negedge CLK); #1;
         n++;
      end
      if (n >= 4000) begin
         chk($sformatf("send_timeout[%0d]", k), 0, 1);
         tv[k] = 1'b0;
      end else begin
         td[k] = d;
         tv[k] = 1'b1;
         st = (per + 1 > lend[k]) ? per + 1 : lend[k];
         lend[k] = st + flen(k);
         exp_q[k].push_back(d);
         st_q[k].push_back(st);
         @(negedge CLK); #1;
         tv[k] = 1'b0;
         td[k] = 8'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!all_idle() && n < 8000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 8000) chk("idle_timeout", 0, 1);
      repeat (48) @(negedge CLK);
   endtask

   task automatic rand_traffic(input int k);
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 40)) @(negedge CLK);
         send(k, 8'($urandom), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      int n;
      RESET = 1'b1;
      for (int k = 0; k < NI; k++) begin
         tv[k] = 1'b0; td[k] = 8'h00; lend[k] = 0; mbusy[k] = 1'b0;
         mlen[k] = 0; midx[k] = 0; done_exp[k] = 0; dcnt[k] = 0; mbits[k] = '1;
      end
      repeat (5) @(posedge CLK);
      #1;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("rst_tx[%0d]", k), 32'(tx[k]), 1);
         chk($sformatf("rst_ready[%0d]", k), 32'(trdy[k]), 1);
         chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 0);
         chk($sformatf("rst_done[%0d]", k), 32'(done[k]), 0);
      end
      @(negedge CLK);
      RESET = 1'b0;

      // 0x55 8N1 single frame
      send(0, 8'h55, 1'b0);
      wait_idle();
      chk("done_55", dcnt[0], 1);

      // 0xA5 then 0x3C back-to-back
      send(0, 8'hA5, 1'b0);
      chk("ready_after_a5", 32'(trdy[0]), 0);
      send(0, 8'h3C, 1'b0);
      chk("ready_after_3c", 32'(trdy[0]), 0);
      wait_idle();

      // 0x07 even and odd parity, 0xFF 7N2
      fork
         send(1, 8'h07, 1'b0);
         send(2, 8'h07, 1'b0);
         send(3, 8'hFF, 1'b0);
      join
      wait_idle();

      // Accept on the same edge as a tick in IDLE
      send(0, 8'h3A, 1'b1);
      wait_idle();

      // Valid offered then withdrawn while the holding register is full
      send(0, 8'h12, 1'b0);
      send(0, 8'h34, 1'b0);
      chk("ready_held", 32'(trdy[0]), 0);
      td[0] = 8'hEE;
      tv[0] = 1'b1;
      repeat (3) @(negedge CLK);
      tv[0] = 1'b0;
      wait_idle();

      // Reset during data bit 3 of 0xC3, with 0x99 waiting in the holding register
      send(0, 8'hC3, 1'b0);
      send(0, 8'h99, 1'b0);
      n = 0;
      while (!(mbusy[0] && midx[0] == 5) && n < 4000) begin
         @(negedge CLK); #1;
         n++;
      end
      if (n >= 4000) chk("reset_wait_timeout", 0, 1);
      in_reset = 1'b1;
      RESET = 1'b1;
      @(posedge CLK); #1;
      chk("midrst_tx", 32'(tx[0]), 1);
      chk("midrst_busy", 32'(busy[0]), 0);
      chk("midrst_ready", 32'(trdy[0]), 1);
      chk("midrst_done", 32'(done[0]), 0);
      for (int k = 0; k < NI; k++) begin
         exp_q[k].delete();
         st_q[k].delete();
         lend[k] = 0;
         mbusy[k] = 1'b0;
      end
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      in_reset = 1'b0;
      send(0, 8'h81, 1'b0);
      wait_idle();

      // Randomised traffic on all configurations
      fork
         rand_traffic(0);
         rand_traffic(1);
         rand_traffic(2);
         rand_traffic(3);
      join
      wait_idle();

      for (int k = 0; k < NI; k++) begin
         chk($sformatf("done_count[%0d]", k), dcnt[k], done_exp[k]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
